mips_halt_dump: RTL and testbench

- Read-side counterpart to the register-file preload used by the pipeline bench.
- When the core asserts HALTED, the block walks the register file through a synchronous read port and streams every register out on a valid/ready channel.
- Sits beside mips_pipe; feeds a debug UART/trace sink or a bench scoreboard, replacing hierarchical peeks into the register array.

---
 rtl/mips_halt_dump.sv | 109 ++++++++++
 tb/tb_mips_halt_dump.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/mips_halt_dump.sv
// mips_halt_dump: streams the register file out over valid/ready once the core halts; optional MIPS_DUMP_CHECKSUM_EN appends an XOR beat
module mips_halt_dump #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int AW   = 5
) (
  input  logic          clk1,
  input  logic          rst,
  input  logic          halted,
  output logic          rf_rd_en,
  output logic [AW-1:0] rf_rd_addr,
  input  logic [DW-1:0] rf_rd_data,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [DW-1:0] dump_data,
  output logic [AW-1:0] dump_idx,
  output logic          dump_last,
  output logic          busy,
  output logic          done
);
`ifdef MIPS_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, CSUM, DONE} state_t;
  logic [DW-1:0] r_csum;
`else
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SEND, DONE} state_t;
`endif
  state_t        r_state, w_next;
  logic [AW-1:0] r_idx;
  logic [DW-1:0] r_data;
  logic          r_armed;
  logic          w_fire, w_end, w_trig;
  assign w_fire = dump_valid && dump_ready;
  assign w_end  = r_idx == AW'(NREG - 1);
  assign w_trig = r_state == IDLE && r_armed && halted;
  // state register; reset aborts any dump in flight
  always_ff @(posedge clk1 or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  // next state and all outputs decoded from the current state
  always_comb begin
    w_next     = r_state;
    rf_rd_en   = 1'b0;
    rf_rd_addr = '0;
    dump_valid = 1'b0;
    dump_data  = r_data;
    dump_idx   = r_idx;
    dump_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (r_state)
      IDLE: w_next = w_trig ? REQ : IDLE;
      REQ: begin
        rf_rd_en   = 1'b1;
        rf_rd_addr = r_idx;
        busy       = 1'b1;
        w_next     = WAIT;
      end
      WAIT: begin
        busy   = 1'b1;
        w_next = SEND;
      end
      SEND: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
`ifdef MIPS_DUMP_CHECKSUM_EN
        w_next     = w_fire ? (w_end ? CSUM : REQ) : SEND;
`else
        dump_last  = w_end;
        w_next     = w_fire ? (w_end ? DONE : REQ) : SEND;
`endif
      end
`ifdef MIPS_DUMP_CHECKSUM_EN
      CSUM: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        dump_data  = r_csum;
        dump_idx   = '0;
        dump_last  = 1'b1;
        w_next     = w_fire ? DONE : CSUM;
      end
`endif
      DONE: begin
        done   = 1'b1;
        w_next = halted ? DONE : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // index, captured word, rearm flag and checksum accumulator
  always_ff @(posedge clk1 or posedge rst)
    if (rst) begin
      r_idx   <= '0;
      r_data  <= '0;
      r_armed <= 1'b1;
`ifdef MIPS_DUMP_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      if (w_trig) r_armed <= 1'b0;
      else if ((r_state == IDLE || r_state == DONE) && !halted) r_armed <= 1'b1;
      if (w_trig || r_state == DONE) r_idx <= '0;
      else if (r_state == SEND && w_fire && !w_end) r_idx <= r_idx + AW'(1);
      if (r_state == WAIT) r_data <= rf_rd_data;
`ifdef MIPS_DUMP_CHECKSUM_EN
      if (w_trig) r_csum <= '0;
      else if (r_state == WAIT) r_csum <= r_csum ^ rf_rd_data;
`endif
    end
endmodule

// File: tb/tb_mips_halt_dump.sv
// tb_mips_halt_dump: scoreboard bench for the halt-time register dump
module tb_mips_halt_dump;
  localparam int NREG = 32;
  localparam int DW   = 32;
  localparam int AW   = 5;
`ifdef MIPS_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  logic clk1 = 1'b0;
  logic rst, halted, rf_rd_en, dump_valid, dump_ready, dump_last, busy, done;
  logic [AW-1:0] rf_rd_addr, dump_idx;
  logic [DW-1:0] rf_rd_data, dump_data;
  logic [DW-1:0] regb [NREG];
  logic [DW+AW:0] q [$];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk1 = ~clk1;

  mips_halt_dump #(.NREG(NREG), .DW(DW), .AW(AW)) dut (
    .clk1(clk1), .rst(rst), .halted(halted),
    .rf_rd_en(rf_rd_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_idx(dump_idx), .dump_last(dump_last), .busy(busy), .done(done)
  );

  always @(posedge clk1) if (rf_rd_en) rf_rd_data <= regb[rf_rd_addr];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk1)
    if (dump_valid && dump_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected beat: got idx %0d data %0h want none", dump_idx, dump_data);
      end else begin
        logic [DW+AW:0] e;
        e = q.pop_front();
        chk($sformatf("beat idx%0d", e[DW+:AW]), {dump_last, dump_idx, dump_data}, e);
      end
    end

  task automatic push_dump();
    logic [DW-1:0] cs;
    cs = '0;
    for (int k = 0; k < NREG; k++) begin
      q.push_back({(k == NREG - 1) && (CS == 0), AW'(k), regb[k]});
      cs ^= regb[k];
    end
    if (CS != 0) q.push_back({1'b1, AW'(0), cs});
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    chk(name, done, 1);
  endtask

  task automatic find_idx(input string name, input int k);
    int n;
    n = 0;
    while (!(dump_valid && dump_idx == AW'(k)) && n < 300) begin
      tick();
      n++;
    end
    chk(name, dump_valid && dump_idx == AW'(k), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, beats;
    rst = 1'b1;
    halted = 1'b0;
    dump_ready = 1'b1;
    for (int k = 0; k < NREG; k++) regb[k] = DW'(k);
    tick();
    tick();
    chk("reset outputs", {rf_rd_en, rf_rd_addr, dump_valid, dump_data, dump_idx, dump_last, busy, done}, 0);
    rst = 1'b0;
    tick();
    chk("idle outputs", {rf_rd_en, dump_valid, busy, done}, 0);

    push_dump();
    halted = 1'b1;
    tick();
    halted = 1'b0;
    chk("busy after trigger", busy, 1);
    chk("first read strobe", {rf_rd_en, rf_rd_addr}, {1'b1, AW'(0)});
    n = 0;
    while (!done && n < 1000) begin
      tick();
      n++;
    end
    chk("done latency", n, 3 * NREG + CS);
    tick();
    chk("back to idle", {done, busy}, 0);
    chk("basic queue drained", q.size(), 0);

    push_dump();
    halted = 1'b1;
    find_idx("reach idx7", 7);
    dump_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp hold", {dump_valid, dump_idx, dump_data, rf_rd_en}, {1'b1, AW'(7), DW'(7), 1'b0});
    end
    dump_ready = 1'b1;
    tick();
    chk("read idx8 after release", {rf_rd_en, rf_rd_addr}, {1'b1, AW'(8)});
    wait_done("bp done", n);
    chk("bp queue drained", q.size(), 0);

    beats = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dump_valid || rf_rd_en) beats++;
    end
    chk("no redump while halted", beats, 0);
    chk("done held", {done, busy}, {1'b1, 1'b0});
    halted = 1'b0;
    tick();
    chk("done clears on rearm", done, 0);

    regb[1] = 32'd5;
    regb[4] = 32'd15;
    regb[5] = 32'd12;
    push_dump();
    halted = 1'b1;
    tick();
    chk("second dump busy", busy, 1);
    wait_done("program done", n);
    chk("program queue drained", q.size(), 0);
    halted = 1'b0;
    tick();

    push_dump();
    halted = 1'b1;
    find_idx("reach idx10", 10);
    dump_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("async reset outputs", {rf_rd_en, dump_valid, dump_data, dump_idx, dump_last, busy, done}, 0);
    q.delete();
    tick();
    tick();
    rst = 1'b0;
    dump_ready = 1'b1;
    push_dump();
    tick();
    chk("fresh dump reads idx0", {rf_rd_en, rf_rd_addr}, {1'b1, AW'(0)});
    wait_done("fresh dump done", n);
    chk("fresh queue drained", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
